// File: rtl/alu_acc_sequencer_if.sv
// Bus bundle for alu_acc_sequencer: instruction channel, ALU drive/return
// and result channel. The sequencer takes the slave view, the surrounding
// environment (instruction source, ALU, result consumer) takes the master view.
// Optional macro: ALU_SEQ_CARRY_EN adds out_carry.
interface alu_acc_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_load;
   logic [2:0] in_op;
   logic [3:0] in_operand;

   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic [3:0] alu_result;

   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_zero;
   logic       busy;
`ifdef ALU_SEQ_CARRY_EN
   logic       out_carry;
`endif

`ifdef ALU_SEQ_CARRY_EN
   modport master (
      output in_valid, in_load, in_op, in_operand, alu_result, out_ready,
      input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_zero,
             busy, out_carry
   );
   modport slave (
      input  in_valid, in_load, in_op, in_operand, alu_result, out_ready,
      output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_zero,
             busy, out_carry
   );
`else
   modport master (
      output in_valid, in_load, in_op, in_operand, alu_result, out_ready,
      input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_zero,
             busy
   );
   modport slave (
      input  in_valid, in_load, in_op, in_operand, alu_result, out_ready,
      output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_zero,
             busy
   );
`endif
endinterface

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: buffers {load, op, operand} instructions in a small
// FIFO, drives the external combinational ALU from the accumulator and the
// FIFO head, writes the result back and offers every new accumulator value
// on a valid/ready channel (one result per two cycles when unstalled).
// Optional macro: ALU_SEQ_CARRY_EN adds a registered carry/borrow output.
module alu_acc_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_acc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   state_t           state;
   state_t           state_nxt;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;

   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;

   logic [7:0]       head;
   logic             head_load;
   logic [2:0]       head_op;
   logic [3:0]       head_operand;

   logic [3:0]       acc;
   logic [3:0]       acc_nxt;
   logic             zero_q;

   assign fifo_empty   = (count == '0);
   assign fifo_full    = (count == FULL_CNT);
   assign push         = bus.in_valid && !fifo_full;
   assign pop          = (state == EXEC);

   assign head         = mem[rd_ptr];
   assign head_load    = head[7];
   assign head_op      = head[6:4];
   assign head_operand = head[3:0];

   assign acc_nxt      = head_load ? head_operand : bus.alu_result;

   // FIFO storage: written on every accepted instruction, never reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.in_load, bus.in_op, bus.in_operand};
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally modulo DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state; RESP looks at the registered count only, so an entry
   // pushed in the handshake cycle is picked up one cycle later via IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (bus.out_ready) begin
               state_nxt = fifo_empty ? IDLE : EXEC;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // FSM outputs and combinational ALU/handshake drive
   always_comb begin
      bus.out_valid = (state == RESP);
      bus.busy      = !fifo_empty || (state != IDLE);
      bus.in_ready  = !fifo_full;
      bus.alu_a     = acc;
      bus.alu_b     = fifo_empty ? 4'd0 : head_operand;
      bus.alu_sel   = fifo_empty ? 3'b000 : head_op;
      bus.out_data  = acc;
      bus.out_zero  = zero_q;
   end

   // Accumulator and zero flag, updated only when an instruction executes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         zero_q <= 1'b1;
      end else if (state == EXEC) begin
         acc    <= acc_nxt;
         zero_q <= (acc_nxt == 4'd0);
      end
   end

`ifdef ALU_SEQ_CARRY_EN
   logic [4:0] eval;
   logic       carry_nxt;
   logic       carry_q;

   // 5-bit re-evaluation of the arithmetic ops; bit 4 is carry or borrow
   always_comb begin
      eval = '0;
      if (!head_load) begin
         case (head_op)
            3'b000:  eval = {1'b0, acc} + {1'b0, head_operand};
            3'b001:  eval = {1'b0, acc} - {1'b0, head_operand};
            3'b110:  eval = {1'b0, acc} + 5'd1;
            3'b111:  eval = {1'b0, acc} - 5'd1;
            default: eval = '0;
         endcase
      end
      carry_nxt = (eval > 5'd15);
   end

   // Carry register, captured alongside the accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_q <= 1'b0;
      end else if (state == EXEC) begin
         carry_q <= carry_nxt;
      end
   end

   assign bus.out_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Testbench for alu_acc_sequencer: models the external ALU, keeps a
// reference accumulator, and scoreboards every result handshake.
module tb_alu_acc_sequencer;

   logic clk;
   logic rst_n;

   alu_acc_sequencer_if bus ();

   alu_acc_sequencer #(
      .DEPTH (4),
      .PTR_W (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] data;
      logic       zero;
      logic       carry;
   } sb_t;

   sb_t         sb [$];
   logic [3:0]  m_acc;
   int unsigned n_vec;
   int unsigned n_err;
   int unsigned n_acc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
      case (s)
         3'd0:    return 4'(a + b);
         3'd1:    return 4'(a - b);
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return 4'(a + 4'd1);
         default: return 4'(a - 4'd1);
      endcase
   endfunction

   assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: compute the result of an accepted instruction in order
   function automatic void sb_push(input logic ld, input logic [2:0] op, input logic [3:0] v);
      sb_t r;
      logic [3:0] nv;
      r.carry = 1'b0;
      if (!ld) begin
         case (op)
            3'd0:    r.carry = (int'(m_acc) + int'(v)) > 15;
            3'd1:    r.carry = (v > m_acc);
            3'd6:    r.carry = (m_acc == 4'd15);
            3'd7:    r.carry = (m_acc == 4'd0);
            default: r.carry = 1'b0;
         endcase
      end
      nv     = ld ? v : alu_f(m_acc, v, op);
      m_acc  = nv;
      r.data = nv;
      r.zero = (nv == 4'd0);
      sb.push_back(r);
   endfunction

   // Result monitor: every handshake must match the next expected entry
   always @(negedge clk) begin
      sb_t e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            check("unexp_out", 32'(bus.out_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("out_data", 32'(bus.out_data), 32'(e.data));
            check("out_zero", 32'(bus.out_zero), 32'(e.zero));
`ifdef ALU_SEQ_CARRY_EN
            check("out_carry", 32'(bus.out_carry), 32'(e.carry));
`endif
         end
      end
   end

   // Offer one instruction, starting just after a rising edge; returns
   // just after the edge that accepted it
   task automatic push(input logic ld, input logic [2:0] op, input logic [3:0] v);
      int unsigned waited;
      waited         = 0;
      bus.in_valid   = 1'b1;
      bus.in_load    = ld;
      bus.in_op      = op;
      bus.in_operand = v;
      @(negedge clk);
      while (!bus.in_ready && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         check("push_timeout", 32'(bus.in_ready), 32'd1);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
      end else begin
         @(posedge clk);
         sb_push(ld, op, v);
         n_acc++;
         #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int unsigned n;
      n = 0;
      @(negedge clk);
      while ((bus.busy || sb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_busy", 32'(bus.busy), 32'd0);
      check("drain_sb", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned base;
      n_vec          = 0;
      n_err          = 0;
      n_acc          = 0;
      m_acc          = 4'd0;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_load    = 1'b0;
      bus.in_op      = 3'd0;
      bus.in_operand = 4'd0;
      bus.out_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_zero", 32'(bus.out_zero), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
`ifdef ALU_SEQ_CARRY_EN
      check("rst_carry", 32'(bus.out_carry), 32'd0);
`endif
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;

      // load 5 then add 3, back to back, with latency and ALU drive checks
      bus.in_valid   = 1'b1;
      bus.in_load    = 1'b1;
      bus.in_op      = 3'd0;
      bus.in_operand = 4'd5;
      @(posedge clk);
      sb_push(1'b1, 3'd0, 4'd5);
      #1;
      bus.in_load    = 1'b0;
      bus.in_operand = 4'd3;
      @(negedge clk);
      check("lat_c0", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      sb_push(1'b0, 3'd0, 4'd3);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("lat_c1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("lat_c2", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      check("exec_valid", 32'(bus.out_valid), 32'd0);
      check("exec_alu_a", 32'(bus.alu_a), 32'd5);
      check("exec_alu_b", 32'(bus.alu_b), 32'd3);
      check("exec_alu_sel", 32'(bus.alu_sel), 32'd0);
      drain();

      // wrap to zero with carry, borrow, and the remaining ops
      push(1'b1, 3'd0, 4'd15);
      push(1'b0, 3'd6, 4'd0);
      drain();
      push(1'b1, 3'd0, 4'd0);
      push(1'b0, 3'd7, 4'd0);
      push(1'b1, 3'd0, 4'd9);
      push(1'b0, 3'd4, 4'd6);
      push(1'b0, 3'd1, 4'd10);
      push(1'b0, 3'd2, 4'd12);
      push(1'b0, 3'd3, 4'd3);
      push(1'b0, 3'd5, 4'd0);
      push(1'b0, 3'd0, 4'd9);
      drain();

      // back-pressure: six offers, five accepted while the result is held
      bus.out_ready = 1'b0;
      base          = n_acc;
      fork
         begin
            push(1'b1, 3'd0, 4'd2);
            push(1'b0, 3'd0, 4'd4);
            push(1'b0, 3'd1, 4'd1);
            push(1'b0, 3'd6, 4'd0);
            push(1'b0, 3'd4, 4'd15);
            push(1'b0, 3'd7, 4'd0);
         end
         begin
            repeat (12) @(posedge clk);
            #2;
            check("full_in_ready", 32'(bus.in_ready), 32'd0);
            check("full_accepted", 32'(n_acc - base), 32'd5);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.out_data), 32'd2);
            bus.out_ready = 1'b1;
         end
      join
      drain();

      // asynchronous reset while a result is held and three entries wait
      bus.out_ready = 1'b0;
      push(1'b1, 3'd0, 4'd7);
      push(1'b0, 3'd0, 4'd1);
      push(1'b0, 3'd0, 4'd1);
      push(1'b0, 3'd0, 4'd1);
      @(negedge clk);
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(bus.out_valid), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_data", 32'(bus.out_data), 32'd0);
      check("arst_zero", 32'(bus.out_zero), 32'd1);
      check("arst_in_ready", 32'(bus.in_ready), 32'd1);
      sb.delete();
      m_acc = 4'd0;
      #3;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(bus.busy), 32'd0);

      // push during EXEC with DEPTH-1 queued: count holds, pointers wrap
      bus.out_ready = 1'b0;
      push(1'b1, 3'd0, 4'd2);
      push(1'b0, 3'd0, 4'd1);
      push(1'b0, 3'd0, 4'd3);
      push(1'b0, 3'd1, 4'd2);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("pp_exec_in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid   = 1'b1;
      bus.in_load    = 1'b0;
      bus.in_op      = 3'd4;
      bus.in_operand = 4'd5;
      @(posedge clk);
      sb_push(1'b0, 3'd4, 4'd5);
      #1;
      bus.in_valid = 1'b0;
      check("pp_in_ready", 32'(bus.in_ready), 32'd1);
      push(1'b0, 3'd6, 4'd0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
